// File: rtl/bk_seq_add_pkg.sv
// Shared definitions for the byte-serial Brent-Kung adder: FSM encoding,
// byte width and the byte-index width helper.
package bk_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // A single-byte operand still needs a 1-bit index register.
  function automatic int idx_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/bk_seq_add_bkadd8.sv
// 8-bit Brent-Kung parallel-prefix adder, purely combinational.
// The carry-in is folded into the bit-0 generate term.
module BKadd8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] g, p, c;
  logic g0, g10, g32, p32, g54, p54, g76, p76;
  logic g30, g74, p74, g70, g50, g20, g40, g60;

  always_comb begin
    g = a & b;
    p = a ^ b;
    g0  = g[0] | (p[0] & cin);
    // Up-sweep: pairs, then quads, then the full byte.
    g10 = g[1] | (p[1] & g0);
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g54 = g[5] | (p[5] & g[4]);
    p54 = p[5] & p[4];
    g76 = g[7] | (p[7] & g[6]);
    p76 = p[7] & p[6];
    g30 = g32 | (p32 & g10);
    g74 = g76 | (p76 & g54);
    p74 = p76 & p54;
    g70 = g74 | (p74 & g30);
    // Down-sweep fills in the remaining prefixes.
    g50 = g54 | (p54 & g30);
    g20 = g[2] | (p[2] & g10);
    g40 = g[4] | (p[4] & g30);
    g60 = g[6] | (p[6] & g50);
    c    = {g60, g50, g40, g30, g20, g10, g0, cin};
    s    = p ^ c;
    cout = g70;
  end

endmodule

// File: rtl/bk_seq_add.sv
// WIDTH-bit adder built by sequencing one BKadd8 over the operands, LSB byte
// first. Optional signed overflow output is enabled with BKSEQ_OVF_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; in_ready is high only in IDLE, res_valid only in DONE, and res_ready
// outside DONE is ignored.
module bk_seq_add
  import bk_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef BKSEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB = WIDTH / BYTE_W;
  localparam int IW = idx_w(NB);

  state_t            state;
  logic [WIDTH-1:0]  op_a, op_b;
  logic              carry;
  logic [IW-1:0]     idx;
  logic [BYTE_W-1:0] sum8;
  logic              c8;

  BKadd8 u_add (
    .a    (op_a[BYTE_W-1:0]),
    .b    (op_b[BYTE_W-1:0]),
    .cin  (carry),
    .s    (sum8),
    .cout (c8)
  );

  assign in_ready  = (state == ST_IDLE);
  assign res_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
`ifdef BKSEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            s     <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NB; i++) begin
            if (idx == IW'(i)) s[BYTE_W*i +: BYTE_W] <= sum8;
          end
          carry <= c8;
          op_a  <= op_a >> BYTE_W;
          op_b  <= op_b >> BYTE_W;
          idx   <= idx + 1'b1;
          if (idx == IW'(NB - 1)) begin
            cout  <= c8;
`ifdef BKSEQ_OVF_EN
            // Carry into bit WIDTH-1 is recovered from the top byte's sum bit.
            ovf   <= (op_a[BYTE_W-1] ^ op_b[BYTE_W-1] ^ sum8[BYTE_W-1]) ^ c8;
`endif
            idx   <= '0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
